// File: rtl/pulse_scan_seq_pkg.sv
// Shared definitions for the pulser phase-scan sequencer:
// pulser register map, FSM states and the phase-word helper.
package pulse_scan_seq_pkg;

  localparam int unsigned ADDR_RST    = 0;
  localparam int unsigned ADDR_START  = 1;
  localparam int unsigned ADDR_DELAY  = 3;
  localparam int unsigned ADDR_WIDTH  = 7;
  localparam int unsigned ADDR_REPEAT = 11;
  localparam int unsigned ADDR_PH_LO  = 15;
  localparam int unsigned ADDR_PH_HI  = 16;

  localparam logic [3:0] CFG_BYTES = 4'd12;
  localparam logic [3:0] PH_BYTES  = 4'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_CFG,
    S_PHASE,
    S_FIRE,
    S_ARM,
    S_POLL,
    S_CHECK,
    S_GAP,
    S_FINISH
  } state_e;

  function automatic logic [15:0] phase_word(
    input logic [3:0] k
  );
    return 16'hFFFF << k;
  endfunction

endpackage

// File: rtl/pulse_scan_seq_wr.sv
// Byte serialiser: turns a start address, byte count and payload
// into consecutive single-byte writes, one per cycle.
module pg_bus_wr_seq #(
  parameter int unsigned ABUSWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [ABUSWIDTH-1:0] start_add,
  input  logic [3:0]           count,
  input  logic [111:0]         payload,
  output logic                 wr_nxt,
  output logic [ABUSWIDTH-1:0] add_nxt,
  output logic [7:0]           data_nxt,
  output logic                 busy
);

  logic [3:0]           rem_q, rem_d;
  logic [ABUSWIDTH-1:0] add_q, add_d;
  logic [103:0]         pay_q, pay_d;

  // Outputs describe the write the parent registers for next cycle.
  always_comb begin
    rem_d    = rem_q;
    add_d    = add_q;
    pay_d    = pay_q;
    wr_nxt   = 1'b0;
    add_nxt  = add_q;
    data_nxt = pay_q[7:0];
    if (start) begin
      wr_nxt   = 1'b1;
      add_nxt  = start_add;
      data_nxt = payload[7:0];
      rem_d    = count - 4'd1;
      add_d    = start_add + ABUSWIDTH'(1);
      pay_d    = payload[111:8];
    end else if (flush) begin
      rem_d = '0;
    end else if (rem_q != '0) begin
      wr_nxt = 1'b1;
      rem_d  = rem_q - 4'd1;
      add_d  = add_q + ABUSWIDTH'(1);
      pay_d  = pay_q >> 8;
    end
  end

  assign busy = (rem_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      add_q <= '0;
      pay_q <= '0;
    end else begin
      rem_q <= rem_d;
      add_q <= add_d;
      pay_q <= pay_d;
    end
  end

endmodule

// File: rtl/pulse_scan_seq.sv
// Phase-scan sequencer: programs the pulser, then fires and
// polls it once per phase index across the configured range.
module pulse_scan_seq #(
  parameter int unsigned ABUSWIDTH = 16,
  parameter logic [31:0] TIMEOUT   = 32'd1_000_000,
  parameter int unsigned ARM_WAIT  = 8
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [31:0]          CFG_DELAY,
  input  logic [31:0]          CFG_WIDTH,
  input  logic [31:0]          CFG_REPEAT,
  input  logic [3:0]           CFG_PHASE_FIRST,
  input  logic [3:0]           CFG_PHASE_LAST,
  input  logic [15:0]          CFG_GAP,
  output logic [ABUSWIDTH-1:0] PG_ADD,
  output logic [7:0]           PG_DATA_OUT,
  input  logic [7:0]           PG_DATA_IN,
  output logic                 PG_WR,
  output logic                 PG_RD,
  output logic                 BUSY,
  output logic [3:0]           STEP,
  output logic                 STEP_DONE,
  output logic                 SCAN_DONE,
  output logic                 ERROR
);
  import pulse_scan_seq_pkg::*;

  state_e               state_q, state_d;
  logic [3:0]           step_q, step_d;
  logic [3:0]           last_q, last_d;
  logic [15:0]          gap_q, gap_d;
  logic                 dir_q, dir_d;
  logic                 err_q, err_d;
  logic                 abrt_q, abrt_d;
  logic [15:0]          wait_q, wait_d;
  logic [31:0]          to_q, to_d;
  logic                 pg_wr_q, pg_wr_d;
  logic                 pg_rd_q, pg_rd_d;
  logic [ABUSWIDTH-1:0] pg_add_q, pg_add_d;
  logic [7:0]           pg_data_q, pg_data_d;
  logic                 busy_q, busy_d;
  logic                 sdone_q, sdone_d;
  logic                 scdone_q, scdone_d;

  logic                 ser_start, ser_flush;
  logic [ABUSWIDTH-1:0] ser_add;
  logic [3:0]           ser_cnt;
  logic [111:0]         ser_pay;
  logic                 ser_wr, ser_busy;
  logic [ABUSWIDTH-1:0] ser_add_nxt;
  logic [7:0]           ser_data_nxt;
  logic                 unused_rd;

  assign unused_rd = ^PG_DATA_IN[7:1];

  pg_bus_wr_seq #(
    .ABUSWIDTH(ABUSWIDTH)
  ) u_wr (
    .clk      (BUS_CLK),
    .rst      (BUS_RST),
    .start    (ser_start),
    .flush    (ser_flush),
    .start_add(ser_add),
    .count    (ser_cnt),
    .payload  (ser_pay),
    .wr_nxt   (ser_wr),
    .add_nxt  (ser_add_nxt),
    .data_nxt (ser_data_nxt),
    .busy     (ser_busy)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    last_d    = last_q;
    gap_d     = gap_q;
    dir_d     = dir_q;
    err_d     = err_q;
    abrt_d    = abrt_q;
    wait_d    = wait_q;
    to_d      = to_q;
    sdone_d   = 1'b0;
    scdone_d  = 1'b0;
    ser_start = 1'b0;
    ser_flush = 1'b0;
    ser_add   = ABUSWIDTH'(ADDR_DELAY);
    ser_cnt   = CFG_BYTES;
    ser_pay   = {16'd0, CFG_REPEAT, CFG_WIDTH, CFG_DELAY};
    if (ABORT && state_q != S_IDLE && state_q != S_FINISH) begin
      state_d   = S_FINISH;
      abrt_d    = 1'b1;
      ser_flush = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            if (CFG_REPEAT == '0) begin
              err_d    = 1'b1;
              scdone_d = 1'b1;
            end else begin
              err_d     = 1'b0;
              abrt_d    = 1'b0;
              step_d    = CFG_PHASE_FIRST;
              last_d    = CFG_PHASE_LAST;
              gap_d     = CFG_GAP;
              dir_d     = CFG_PHASE_FIRST > CFG_PHASE_LAST;
              state_d   = S_WR_CFG;
              ser_start = 1'b1;
            end
          end
        end
        S_WR_CFG: begin
          if (!ser_busy) begin
            state_d   = S_PHASE;
            ser_start = 1'b1;
            ser_add   = ABUSWIDTH'(ADDR_PH_LO);
            ser_cnt   = PH_BYTES;
            ser_pay   = {96'd0, phase_word(step_q)};
          end
        end
        S_PHASE: begin
          if (!ser_busy) state_d = S_FIRE;
        end
        S_FIRE: begin
          wait_d  = '0;
          to_d    = '0;
          state_d = (ARM_WAIT == 0) ? S_POLL : S_ARM;
        end
        S_ARM: begin
          to_d = to_q + 32'd1;
          if (wait_q == 16'(ARM_WAIT - 1)) state_d = S_POLL;
          else wait_d = wait_q + 16'd1;
        end
        S_POLL: begin
          to_d    = to_q + 32'd1;
          state_d = S_CHECK;
        end
        S_CHECK: begin
          to_d = to_q + 32'd1;
          if (PG_DATA_IN[0]) begin
            sdone_d = 1'b1;
            wait_d  = '0;
            state_d = S_GAP;
          end else if (to_q >= TIMEOUT) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            state_d = S_POLL;
          end
        end
        S_GAP: begin
          // Gap of 0 or 1 both leave after a single cycle.
          if (({1'b0, wait_q} + 17'd1) >= {1'b0, gap_q}) begin
            if (step_q == last_q) begin
              state_d = S_FINISH;
            end else begin
              step_d    = dir_q ? step_q - 4'd1 : step_q + 4'd1;
              state_d   = S_PHASE;
              ser_start = 1'b1;
              ser_add   = ABUSWIDTH'(ADDR_PH_LO);
              ser_cnt   = PH_BYTES;
              ser_pay   = {96'd0, phase_word(step_d)};
            end
          end else begin
            wait_d = wait_q + 16'd1;
          end
        end
        S_FINISH: begin
          state_d  = S_IDLE;
          abrt_d   = 1'b0;
          scdone_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Bus outputs are decoded from the next state and registered.
    pg_wr_d   = ser_wr || state_d == S_FIRE ||
                (state_d == S_FINISH && (err_d || abrt_d));
    pg_rd_d   = (state_d == S_POLL);
    pg_add_d  = ABUSWIDTH'(ADDR_RST);
    pg_data_d = '0;
    if (ser_wr) begin
      pg_add_d  = ser_add_nxt;
      pg_data_d = ser_data_nxt;
    end else if (state_d == S_FIRE || state_d == S_POLL) begin
      pg_add_d = ABUSWIDTH'(ADDR_START);
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      last_q    <= '0;
      gap_q     <= '0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      abrt_q    <= 1'b0;
      wait_q    <= '0;
      to_q      <= '0;
      pg_wr_q   <= 1'b0;
      pg_rd_q   <= 1'b0;
      pg_add_q  <= '0;
      pg_data_q <= '0;
      busy_q    <= 1'b0;
      sdone_q   <= 1'b0;
      scdone_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      abrt_q    <= abrt_d;
      wait_q    <= wait_d;
      to_q      <= to_d;
      pg_wr_q   <= pg_wr_d;
      pg_rd_q   <= pg_rd_d;
      pg_add_q  <= pg_add_d;
      pg_data_q <= pg_data_d;
      busy_q    <= busy_d;
      sdone_q   <= sdone_d;
      scdone_q  <= scdone_d;
    end
  end

  assign PG_WR       = pg_wr_q;
  assign PG_RD       = pg_rd_q;
  assign PG_ADD      = pg_add_q;
  assign PG_DATA_OUT = pg_data_q;
  assign BUSY        = busy_q;
  assign STEP        = step_q;
  assign STEP_DONE   = sdone_q;
  assign SCAN_DONE   = scdone_q;
  assign ERROR       = err_q;

endmodule

// File: tb/tb_pulse_scan_seq.sv
// Scoreboard bench for pulse_scan_seq with a behavioural pulser
// model and a queue-based reference of expected bus traffic.
module tb_pulse_scan_seq;

  localparam int unsigned AW = 16;

  logic          BUS_CLK = 1'b0;
  logic          BUS_RST = 1'b1;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic [31:0]   CFG_DELAY = '0;
  logic [31:0]   CFG_WIDTH = '0;
  logic [31:0]   CFG_REPEAT = '0;
  logic [3:0]    CFG_PHASE_FIRST = '0;
  logic [3:0]    CFG_PHASE_LAST = '0;
  logic [15:0]   CFG_GAP = '0;
  logic [AW-1:0] PG_ADD;
  logic [7:0]    PG_DATA_OUT;
  logic [7:0]    PG_DATA_IN = '0;
  logic          PG_WR, PG_RD, BUSY;
  logic [3:0]    STEP;
  logic          STEP_DONE, SCAN_DONE, ERROR;

  pulse_scan_seq #(
    .ABUSWIDTH(AW),
    .TIMEOUT  (32'd50),
    .ARM_WAIT (8)
  ) dut (
    .BUS_CLK        (BUS_CLK),
    .BUS_RST        (BUS_RST),
    .START          (START),
    .ABORT          (ABORT),
    .CFG_DELAY      (CFG_DELAY),
    .CFG_WIDTH      (CFG_WIDTH),
    .CFG_REPEAT     (CFG_REPEAT),
    .CFG_PHASE_FIRST(CFG_PHASE_FIRST),
    .CFG_PHASE_LAST (CFG_PHASE_LAST),
    .CFG_GAP        (CFG_GAP),
    .PG_ADD         (PG_ADD),
    .PG_DATA_OUT    (PG_DATA_OUT),
    .PG_DATA_IN     (PG_DATA_IN),
    .PG_WR          (PG_WR),
    .PG_RD          (PG_RD),
    .BUSY           (BUSY),
    .STEP           (STEP),
    .STEP_DONE      (STEP_DONE),
    .SCAN_DONE      (SCAN_DONE),
    .ERROR          (ERROR)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [3:0] exp_step[$];
  logic       exp_err[$];

  int vectors = 0;
  int miscompares = 0;
  int scans_seen = 0;

  bit hold0 = 1'b0;
  bit fired = 1'b0;
  bit rd_prev = 1'b0;
  int fire_cnt = 0;

  function automatic wr_t mk(input logic [15:0] a,
                             input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Pulser: DONE rises 20 cycles after a fire; read data lands
  // in the cycle after the read strobe.
  always @(negedge BUS_CLK) begin
    if (rd_prev)
      PG_DATA_IN = {7'd0, fired && !hold0 && fire_cnt >= 20};
    rd_prev = PG_RD;
    if (fired) fire_cnt++;
    if (PG_WR && PG_ADD == 16'd1) begin
      fired = 1'b1;
      fire_cnt = 0;
    end
    if (PG_WR && PG_ADD == 16'd0) fired = 1'b0;
  end

  always @(negedge BUS_CLK) begin
    wr_t        w;
    logic [3:0] s;
    logic       e;
    if (PG_WR || PG_RD) begin
      check("wr_rd_excl", 64'(PG_WR && PG_RD), 64'(0));
      check("busy_on_access", 64'(BUSY), 64'(1));
    end
    if (PG_WR) begin
      if (exp_wr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_wr: got add %0d data %0h, required none",
                 PG_ADD, PG_DATA_OUT);
      end else begin
        w = exp_wr.pop_front();
        check("wr_addr", 64'(PG_ADD), 64'(w.a));
        check("wr_data", 64'(PG_DATA_OUT), 64'(w.d));
      end
    end
    if (PG_RD) check("rd_addr", 64'(PG_ADD), 64'(1));
    if (STEP_DONE) begin
      if (exp_step.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_step_done: got step %0d, required none",
                 STEP);
      end else begin
        s = exp_step.pop_front();
        check("step_at_done", 64'(STEP), 64'(s));
      end
    end
    if (SCAN_DONE) begin
      scans_seen++;
      if (exp_err.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_scan_done: got 1, required 0");
      end else begin
        e = exp_err.pop_front();
        check("error_at_scan_done", 64'(ERROR), 64'(e));
      end
    end
  end

  task automatic start_scan(input logic [31:0] dly,
                            input logic [31:0] wid,
                            input logic [31:0] rep,
                            input logic [3:0]  f,
                            input logic [3:0]  l,
                            input logic [15:0] gap,
                            input bit          tmo);
    logic [95:0] cfg;
    logic [15:0] ph;
    int n, k;
    cfg = {rep, wid, dly};
    n = (f <= l) ? int'(l) - int'(f) + 1 : int'(f) - int'(l) + 1;
    if (tmo) n = 1;
    if (rep == 0) begin
      exp_err.push_back(1'b1);
    end else begin
      for (int i = 0; i < 12; i++)
        exp_wr.push_back(mk(16'(3 + i), cfg[i*8 +: 8]));
      for (int j = 0; j < n; j++) begin
        k = (f <= l) ? int'(f) + j : int'(f) - j;
        ph = 16'hFFFF << k;
        exp_wr.push_back(mk(16'd15, ph[7:0]));
        exp_wr.push_back(mk(16'd16, ph[15:8]));
        exp_wr.push_back(mk(16'd1, 8'd0));
        if (!tmo) exp_step.push_back(4'(k));
      end
      if (tmo) exp_wr.push_back(mk(16'd0, 8'd0));
      exp_err.push_back(tmo);
    end
    @(negedge BUS_CLK);
    CFG_DELAY = dly;
    CFG_WIDTH = wid;
    CFG_REPEAT = rep;
    CFG_PHASE_FIRST = f;
    CFG_PHASE_LAST = l;
    CFG_GAP = gap;
    START = 1'b1;
    @(negedge BUS_CLK);
    START = 1'b0;
    if (rep == 0) begin
      check("rep0_scan_done", 64'(SCAN_DONE), 64'(1));
      check("rep0_busy", 64'(BUSY), 64'(0));
    end else begin
      check("start_busy", 64'(BUSY), 64'(1));
      check("start_err_clear", 64'(ERROR), 64'(0));
      check("first_wr", 64'({PG_WR, PG_ADD}), 64'({1'b1, 16'd3}));
    end
  endtask

  task automatic wait_scan(input int target, input int budget);
    int c;
    c = 0;
    while (scans_seen < target && c < budget) begin
      @(negedge BUS_CLK);
      c++;
    end
    check("scan_done_seen", 64'(scans_seen >= target), 64'(1));
  endtask

  task automatic check_drained();
    repeat (3) @(negedge BUS_CLK);
    check("left_wr", 64'(exp_wr.size()), 64'(0));
    check("left_step", 64'(exp_step.size()), 64'(0));
    check("left_done", 64'(exp_err.size()), 64'(0));
  endtask

  task automatic run_scan(input logic [31:0] dly,
                          input logic [31:0] wid,
                          input logic [31:0] rep,
                          input logic [3:0]  f,
                          input logic [3:0]  l,
                          input logic [15:0] gap,
                          input bit          tmo);
    int tgt, cyc;
    tgt = scans_seen + 1;
    start_scan(dly, wid, rep, f, l, gap, tmo);
    if (rep != 0) begin
      cyc = 1;
      while (!PG_RD && cyc < 200) begin
        @(negedge BUS_CLK);
        cyc++;
      end
      check("first_poll_cycle", 64'(cyc), 64'(24));
    end
    wait_scan(tgt, 4000);
    check_drained();
  endtask

  initial begin
    int tgt, c;
    logic [31:0] rd, rw, rr;

    repeat (3) @(negedge BUS_CLK);
    check("reset_state",
          64'({PG_WR, PG_RD, PG_ADD, PG_DATA_OUT, BUSY, STEP,
               STEP_DONE, SCAN_DONE, ERROR}), 64'(0));
    BUS_RST = 1'b0;

    run_scan(32'd5, 32'd3, 32'd2, 4'd0, 4'd3, 16'd4, 1'b0);
    run_scan(32'd1, 32'd1, 32'd0, 4'd0, 4'd3, 16'd0, 1'b0);
    check("rep0_err_sticky", 64'(ERROR), 64'(1));
    run_scan(32'd7, 32'd2, 32'd1, 4'd5, 4'd2, 16'd0, 1'b0);

    hold0 = 1'b1;
    run_scan(32'h11223344, 32'h55, 32'd9, 4'd3, 4'd9, 16'd2, 1'b1);
    hold0 = 1'b0;
    check("timeout_err_sticky", 64'(ERROR), 64'(1));

    // Abort while polling, after an ignored START during the scan.
    tgt = scans_seen + 1;
    start_scan(32'd9, 32'd4, 32'd1, 4'd0, 4'd7, 16'd3, 1'b0);
    repeat (30) @(negedge BUS_CLK);
    CFG_PHASE_LAST = 4'd1;
    CFG_REPEAT = '0;
    START = 1'b1;
    @(negedge BUS_CLK);
    START = 1'b0;
    c = 0;
    while (!(exp_step.size() <= 6 && PG_RD) && c < 2000) begin
      @(negedge BUS_CLK);
      c++;
    end
    check("abort_in_poll", 64'(PG_RD), 64'(1));
    ABORT = 1'b1;
    exp_wr.delete();
    exp_step.delete();
    exp_wr.push_back(mk(16'd0, 8'd0));
    @(negedge BUS_CLK);
    ABORT = 1'b0;
    wait_scan(tgt, 200);
    check("abort_err", 64'(ERROR), 64'(0));
    check_drained();

    // Reset in the middle of the configuration writes.
    start_scan(32'd5, 32'd3, 32'd2, 4'd2, 4'd4, 16'd1, 1'b0);
    repeat (4) @(negedge BUS_CLK);
    BUS_RST = 1'b1;
    @(negedge BUS_CLK);
    check("reset_mid_scan",
          64'({PG_WR, PG_RD, PG_ADD, PG_DATA_OUT, BUSY, STEP,
               STEP_DONE, SCAN_DONE, ERROR}), 64'(0));
    exp_wr.delete();
    exp_step.delete();
    exp_err.delete();
    BUS_RST = 1'b0;
    run_scan(32'd5, 32'd3, 32'd2, 4'd0, 4'd3, 16'd4, 1'b0);

    for (int it = 0; it < 6; it++) begin
      rd = $urandom;
      rw = $urandom;
      rr = $urandom;
      if (rr == 0) rr = 32'd1;
      run_scan(rd, rw, rr,
               4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)),
               16'($urandom_range(0, 6)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
